// File: rtl/vga_mode_seq.sv
// vga_mode_seq: steps a 2-bit VGA colour mode either from a debounced
// pushbutton or automatically every FRAMES_PER_STEP frames.
//
// state  | meaning
// -------+-----------------------------------------------------------
// MANUAL | only button presses step the mode; frame counter held at 0
// AUTO   | frame_done pulses are counted; every FRAMES_PER_STEP-th
//        | one steps the mode; button presses still step and restart
//        | the frame count
module vga_mode_seq #(
   parameter int unsigned FRAMES_PER_STEP = 60,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_done,
   input  logic       btn_step,
   input  logic       auto_en,
   input  logic       dir,
   output logic [1:0] vga_state,
   output logic       step_pulse
);

   typedef enum logic {
      ST_MANUAL = 1'b0,
      ST_AUTO   = 1'b1
   } state_e;

   localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0]  FRM_LAST = 8'(FRAMES_PER_STEP - 1);

   logic        sync1_q, sync2_q;
   logic        deb_q;
   logic [15:0] cnt_q;
   state_e      state_q;
   logic [7:0]  fcnt_q;
   logic [1:0]  vga_state_q;
   logic        step_pulse_q;

   logic        deb_commit;
   logic        press_ev;
   logic        auto_ev;
   logic        step_ev;
   logic [1:0]  vga_state_d;

   // Event decode: a press is the committed 0->1 debounce update; an auto
   // event is the terminal frame of the current step period.
   always_comb begin
      deb_commit  = (sync2_q != deb_q) && (cnt_q == DEB_LAST);
      press_ev    = deb_commit && sync2_q;
      auto_ev     = (state_q == ST_AUTO) && frame_done && (fcnt_q == FRM_LAST);
      step_ev     = press_ev || auto_ev;
      vga_state_d = dir ? (vga_state_q - 2'd1) : (vga_state_q + 2'd1);
   end

   // Synchronize the raw button and debounce it with a mismatch counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_step;
         sync2_q <= sync1_q;
         if (sync2_q == deb_q) begin
            cnt_q <= '0;
         end else if (deb_commit) begin
            deb_q <= sync2_q;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 16'd1;
         end
      end
   end

   // Mode FSM with its frame counter; any step restarts the frame count.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_MANUAL;
         fcnt_q  <= '0;
      end else begin
         case (state_q)
            ST_MANUAL: begin
               fcnt_q <= '0;
               if (auto_en) state_q <= ST_AUTO;
            end
            ST_AUTO: begin
               if (!auto_en) begin
                  state_q <= ST_MANUAL;
                  fcnt_q  <= '0;
               end else if (step_ev) begin
                  fcnt_q <= '0;
               end else if (frame_done) begin
                  fcnt_q <= fcnt_q + 8'd1;
               end
            end
            default: begin
               state_q <= ST_MANUAL;
               fcnt_q  <= '0;
            end
         endcase
      end
   end

   // Registered mode output and its one-cycle step strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         vga_state_q  <= 2'd0;
         step_pulse_q <= 1'b0;
      end else begin
         step_pulse_q <= step_ev;
         if (step_ev) vga_state_q <= vga_state_d;
      end
   end

   assign vga_state  = vga_state_q;
   assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_vga_mode_seq.sv
// tb_vga_mode_seq: scoreboard bench for vga_mode_seq with a behavioural
// reference model, directed scenarios and a randomized phase.
module tb_vga_mode_seq;

   localparam int D = 4;
   localparam int F = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_done = 1'b0;
   logic       btn_step = 1'b0;
   logic       auto_en = 1'b0;
   logic       dir = 1'b0;
   logic [1:0] vga_state;
   logic       step_pulse;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int cyc;
      int vga;
   } exp_t;
   exp_t exp_q[$];

   // reference model state
   int m_s1 = 0, m_s2 = 0, m_deb = 0, m_run = 0;
   int m_fcnt = 0, m_auto = 0, m_vga = 0;

   vga_mode_seq #(.FRAMES_PER_STEP(F), .DEBOUNCE_CYCLES(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .frame_done(frame_done),
      .btn_step  (btn_step),
      .auto_en   (auto_en),
      .dir       (dir),
      .vga_state (vga_state),
      .step_pulse(step_pulse)
   );

   always #5 clk = ~clk;

   // Reference model: debounced level flips once the synchronized button
   // has disagreed with it for D consecutive cycles; in auto mode every
   // F-th frame steps; a press restarts the frame count.
   always @(posedge clk) begin
      int press, autoev;
      exp_t e;
      cyc++;
      press  = 0;
      autoev = 0;
      if (rst) begin
         m_s1 = 0; m_s2 = 0; m_deb = 0; m_run = 0;
         m_fcnt = 0; m_auto = 0; m_vga = 0;
      end else begin
         if (m_s2 != m_deb) m_run++;
         else               m_run = 0;
         if (m_run == D) begin
            m_deb = m_s2;
            m_run = 0;
            press = m_deb;
         end
         if (m_auto != 0 && frame_done) begin
            m_fcnt++;
            if (m_fcnt == F) begin
               autoev = 1;
               m_fcnt = 0;
            end
         end
         if (press != 0) m_fcnt = 0;
         if (m_auto == 0 || !auto_en) m_fcnt = 0;
         m_auto = auto_en ? 1 : 0;
         if (press != 0 || autoev != 0) begin
            m_vga = dir ? (m_vga + 3) % 4 : (m_vga + 1) % 4;
            e.cyc = cyc;
            e.vga = m_vga;
            exp_q.push_back(e);
         end
         m_s2 = m_s1;
         m_s1 = btn_step ? 1 : 0;
      end
   end

   // Monitor: checks the mode every cycle and matches each step pulse
   // against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (cyc > 0) begin
         total++;
         if (vga_state !== 2'(m_vga)) begin
            bad++;
            $display("FAIL vga_state cyc=%0d got=%0d want=%0d", cyc, vga_state, m_vga);
         end
         if (step_pulse === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_pulse cyc=%0d got=1 want=0", cyc);
            end else begin
               e = exp_q.pop_front();
               if (e.cyc != cyc || int'(vga_state) != e.vga) begin
                  bad++;
                  $display("FAIL pulse_match cyc=%0d got_vga=%0d want_vga=%0d want_cyc=%0d",
                           cyc, vga_state, e.vga, e.cyc);
               end
            end
         end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            total++;
            bad++;
            e = exp_q.pop_front();
            $display("FAIL missed_pulse cyc=%0d got=%b want=1 (vga %0d)", cyc, step_pulse, e.vga);
         end
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic frame();
      frame_done = 1'b1;
      tick(1);
      frame_done = 1'b0;
      tick(1);
   endtask

   task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   initial begin
      tick(2);
      check("reset_vga", vga_state, 2'd0);
      check("reset_pulse", {1'b0, step_pulse}, 2'd0);
      rst = 1'b0;
      tick(1);

      // held press: step at edge k+5
      btn_step = 1'b1;
      tick(5);
      check("press_not_early", vga_state, 2'd0);
      tick(1);
      check("press_step", vga_state, 2'd1);
      check("press_pulse", {1'b0, step_pulse}, 2'd1);
      tick(1);
      check("press_pulse_once", {1'b0, step_pulse}, 2'd0);
      btn_step = 1'b0;
      tick(12);
      check("release_no_step", vga_state, 2'd1);

      // glitches shorter than the debounce window
      do_reset();
      for (int g = 0; g < 5; g++) begin
         btn_step = 1'b1;
         tick(3);
         btn_step = 1'b0;
         tick(3);
      end
      tick(8);
      check("glitch_no_step", vga_state, 2'd0);

      // automatic cycling with wrap
      auto_en = 1'b1;
      tick(2);
      for (int p = 1; p <= 12; p++) begin
         frame();
         if (p % 3 == 0) check("auto_seq", vga_state, 2'((p / 3) % 4));
      end
      check("auto_wrap", vga_state, 2'd0);
      auto_en = 1'b0;
      tick(2);

      // stepping down with presses
      dir = 1'b1;
      btn_step = 1'b1;
      tick(8);
      check("down_wrap", vga_state, 2'd3);
      btn_step = 1'b0;
      tick(8);
      btn_step = 1'b1;
      tick(8);
      check("down_again", vga_state, 2'd2);
      btn_step = 1'b0;
      dir = 1'b0;
      tick(8);

      // press coincident with the third frame
      do_reset();
      auto_en = 1'b1;
      tick(2);
      frame();
      frame();
      btn_step = 1'b1;
      tick(5);
      frame_done = 1'b1;
      tick(1);
      frame_done = 1'b0;
      check("coincide_single", vga_state, 2'd1);
      tick(1);
      frame();
      frame();
      check("coincide_restart", vga_state, 2'd1);
      frame();
      check("coincide_next", vga_state, 2'd2);
      btn_step = 1'b0;
      tick(8);

      // reset in the middle of debounce and frame count
      do_reset();
      tick(1);
      frame();
      frame();
      btn_step = 1'b1;
      tick(4);
      btn_step = 1'b0;
      do_reset();
      check("mid_reset_vga", vga_state, 2'd0);
      tick(1);
      frame();
      frame();
      check("mid_reset_no_step", vga_state, 2'd0);
      frame();
      check("mid_reset_step", vga_state, 2'd1);

      // randomized phase, checked by the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) btn_step = ~btn_step;
         frame_done = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 60) == 0) auto_en = ~auto_en;
         dir = $urandom_range(0, 1) != 0;
         rst = ($urandom_range(0, 400) == 0);
         tick(1);
      end
      rst = 1'b0;
      frame_done = 1'b0;
      btn_step = 1'b0;
      tick(12);

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
